mmm_sched: RTL and testbench

- Sequencing controller for the matrix-multiply datapath (input_mems -> mac_pipe -> fifo_out).
- Once input_mems reports matrices loaded, it walks C = A(MxK) * B(KxN) in row-major output order.
- It drives memory read addresses and MAC valid/clear, and times fifo_out writes to the MAC latency.
- Output FIFO space is reserved by credit before each dot product starts, so a result is never dropped and a dot product is never stalled mid-stream.

---
 rtl/mmm_sched.sv | 137 +++++++++++++
 tb/tb_mmm_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mmm_sched.sv
// Walks C=A*B in row-major order, driving read addresses and MAC valid/clear; write strobe lands 1+MAC_LAT cycles after the last element issues.
// Backpressure: a dot product starts only if fifo_capacity_i > inflight, so the element stream never stalls mid-product and no result is ever dropped.
module mmm_sched #(
    parameter int M          = 7,
    parameter int N          = 9,
    parameter int MAXK       = 8,
    parameter int MAC_LAT    = 4,
    parameter int FIFO_DEPTH = 9,
    localparam int K_BITS    = $clog2(MAXK + 1),
    localparam int CAP_BITS  = $clog2(FIFO_DEPTH + 1),
    localparam int AW        = $clog2(M * MAXK),
    localparam int BW        = $clog2(MAXK * N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                matrices_loaded_i,
    input  logic [K_BITS-1:0]   K_i,
    input  logic [CAP_BITS-1:0] fifo_capacity_i,
    output logic [AW-1:0]       A_read_addr_o,
    output logic [BW-1:0]       B_read_addr_o,
    output logic                valid_input_o,
    output logic                clear_acc_o,
    output logic                fifo_wr_en_o,
    output logic                compute_finished_o,
    output logic                busy_o
);
    localparam int R_BITS = (M > 1) ? $clog2(M) : 1;
    localparam int C_BITS = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [R_BITS-1:0]   r_q, r_d;
    logic [C_BITS-1:0]   c_q, c_d;
    logic [K_BITS-1:0]   i_q, i_d;
    logic [K_BITS-1:0]   k_q, k_d;
    logic [CAP_BITS-1:0] inflight_q, inflight_d;
    logic                vld_q, clr_q, last_q, fin_q;
    logic [MAC_LAT-1:0]  tag_q;

    logic issue, start, wr, i_last, c_last, r_last, tags_empty;

    // Credit is only consulted at i==0; the rest of a dot product follows unconditionally.
    assign issue      = (state_q == S_RUN) && ((i_q != '0) || (fifo_capacity_i > inflight_q));
    assign start      = issue && (i_q == '0);
    assign wr         = tag_q[MAC_LAT-1];
    assign i_last     = (i_q == k_q - K_BITS'(1));
    assign c_last     = (c_q == C_BITS'(N - 1));
    assign r_last     = (r_q == R_BITS'(M - 1));
    assign tags_empty = !last_q && (tag_q == '0);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        i_d     = i_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (matrices_loaded_i) begin
                    k_d     = K_i;
                    state_d = (K_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (!i_last) begin
                        i_d = i_q + K_BITS'(1);
                    end else begin
                        i_d = '0;
                        if (!c_last) begin
                            c_d = c_q + C_BITS'(1);
                        end else begin
                            c_d = '0;
                            if (!r_last) begin
                                r_d = r_q + R_BITS'(1);
                            end else begin
                                r_d     = '0;
                                state_d = S_DRAIN;
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                if ((inflight_q == '0) && tags_empty) state_d = S_DONE;
            end
            S_DONE: begin
                if (!matrices_loaded_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        if (start && !wr)      inflight_d = inflight_q + CAP_BITS'(1);
        else if (!start && wr) inflight_d = inflight_q - CAP_BITS'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            i_q        <= '0;
            k_q        <= '0;
            inflight_q <= '0;
            vld_q      <= 1'b0;
            clr_q      <= 1'b0;
            last_q     <= 1'b0;
            tag_q      <= '0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            i_q        <= i_d;
            k_q        <= k_d;
            inflight_q <= inflight_d;
            vld_q      <= issue;
            clr_q      <= start;
            last_q     <= issue && i_last;
            // last_q is aligned with valid_input; MAC_LAT more stages reach the write strobe.
            tag_q      <= (tag_q << 1) | MAC_LAT'(last_q);
            fin_q      <= (state_d == S_DONE) && (state_q != S_DONE);
        end
    end

    assign A_read_addr_o      = AW'(r_q) * AW'(k_q) + AW'(i_q);
    assign B_read_addr_o      = BW'(i_q) * BW'(N) + BW'(c_q);
    assign valid_input_o      = vld_q;
    assign clear_acc_o        = clr_q;
    assign fifo_wr_en_o       = wr;
    assign compute_finished_o = fin_q;
    assign busy_o             = (state_q != S_IDLE);
endmodule

// File: tb/tb_mmm_sched.sv
// Bench for mmm_sched: random K / FIFO size / pop pattern against a row-major element table and a FIFO occupancy model.
module tb_mmm_sched;
    localparam int M = 2, N = 3, MAXK = 4, MAC_LAT = 3, FD = 8;
    localparam int KB = 3, CB = 4, AW = 3, BW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ml = 1'b0;
    logic [KB-1:0] k_in = '0;
    logic [CB-1:0] cap;
    logic [AW-1:0] a_addr;
    logic [BW-1:0] b_addr;
    logic          valid_input, clear_acc, fifo_wr_en, compute_finished, busy;

    mmm_sched #(.M(M), .N(N), .MAXK(MAXK), .MAC_LAT(MAC_LAT), .FIFO_DEPTH(FD)) dut (
        .clk               (clk),
        .reset             (reset),
        .matrices_loaded_i (ml),
        .K_i               (k_in),
        .fifo_capacity_i   (cap),
        .A_read_addr_o     (a_addr),
        .B_read_addr_o     (b_addr),
        .valid_input_o     (valid_input),
        .clear_acc_o       (clear_acc),
        .fifo_wr_en_o      (fifo_wr_en),
        .compute_finished_o(compute_finished),
        .busy_o            (busy)
    );

    always #5 clk = ~clk;

    int fsize = FD, occ = 0, popmode = 1;
    assign cap = (fsize > occ) ? CB'(fsize - occ) : '0;

    int exp_a[$], exp_b[$], pend[$];
    bit exp_clr[$], exp_last[$];
    int cyc = 0, n_vld = 0, n_wr = 0, n_fin = 0;
    int first_v = 0, last_v = 0, first_w = 0, last_w = 0, fin_cyc = 0;
    int prev_a = 0, prev_b = 0;
    int n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: checks element stream, write timing and FIFO room once per cycle.
    always @(negedge clk) begin
        bit exp_w;
        cyc++;
        if (reset) begin
            exp_a.delete(); exp_b.delete(); exp_clr.delete(); exp_last.delete(); pend.delete();
            occ = 0;
        end else begin
            if (valid_input && exp_a.size() > 0) begin
                chk("a_addr", prev_a, exp_a.pop_front());
                chk("b_addr", prev_b, exp_b.pop_front());
                chk("clr", int'(clear_acc), int'(exp_clr.pop_front()));
                if (exp_last.pop_front()) pend.push_back(cyc + MAC_LAT);
                if (n_vld == 0) first_v = cyc;
                last_v = cyc;
                n_vld++;
            end else begin
                chk("vld_unexpected", int'(valid_input), 0);
                chk("clr_idle", int'(clear_acc), 0);
            end
            exp_w = (pend.size() > 0) && (pend[0] == cyc);
            chk("wr_en", int'(fifo_wr_en), int'(exp_w));
            while (pend.size() > 0 && pend[0] <= cyc) void'(pend.pop_front());
            if (fifo_wr_en) begin
                chk("fifo_room", int'(occ < fsize), 1);
                occ++;
                if (n_wr == 0) first_w = cyc;
                last_w = cyc;
                n_wr++;
            end
            if (popmode == 1) occ = 0;
            else if (popmode == 2 && occ > 0 && $urandom_range(1, 0) == 1) occ--;
            if (compute_finished) begin
                n_fin++;
                fin_cyc = cyc;
            end
        end
        prev_a = int'(a_addr);
        prev_b = int'(b_addr);
    end

    task automatic start_run(input int k, input int fs, input int pm);
        @(posedge clk); #1;
        exp_a.delete(); exp_b.delete(); exp_clr.delete(); exp_last.delete();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                for (int i = 0; i < k; i++) begin
                    exp_a.push_back((r * k + i) % (1 << AW));
                    exp_b.push_back((i * N + c) % (1 << BW));
                    exp_clr.push_back(i == 0);
                    exp_last.push_back(i == k - 1);
                end
        n_vld = 0; n_wr = 0; n_fin = 0;
        k_in = KB'(k); fsize = fs; popmode = pm;
        ml = 1'b1;
    endtask

    task automatic wait_fin(input int k);
        for (int w = 0; w < 3000 && n_fin == 0; w++) @(posedge clk);
        #1;
        chk("fin_pulse", n_fin, 1);
        chk("q_empty", exp_a.size() + pend.size(), 0);
        chk("n_vld", n_vld, M * N * k);
        chk("n_wr", n_wr, (k > 0) ? M * N : 0);
        if (k > 0) chk("fin_after_wr", int'(fin_cyc > last_w), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("fin_once", n_fin, 1);
        chk("busy_done", int'(busy), 1);
    endtask

    task automatic drop_ml();
        ml = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);
    endtask

    function automatic int outs();
        return int'({a_addr, b_addr, valid_input, clear_acc, fifo_wr_en, compute_finished, busy});
    endfunction

    initial begin
        #1 reset = 1'b1;
        #1 chk("rst_outs", outs(), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Nominal K=2, ample capacity: 12 back-to-back elements.
        start_run(2, 8, 1);
        wait_fin(2);
        chk("s1_burst", last_v - first_v + 1, 12);
        drop_ml();

        // Capacity 1 and no pops: one product, then a hold until capacity returns.
        start_run(2, 1, 0);
        for (int w = 0; w < 200 && n_wr < 1; w++) @(posedge clk);
        repeat (12) @(posedge clk);
        #1;
        chk("stall_wr", n_wr, 1);
        chk("stall_vld", n_vld, 2);
        chk("stall_vo", int'(valid_input), 0);
        chk("stall_busy", int'(busy), 1);
        fsize = 8;
        wait_fin(2);
        drop_ml();

        // K=1: every element clears; writes on consecutive cycles.
        start_run(1, 8, 1);
        wait_fin(1);
        chk("k1_wr_span", last_w - first_w, 5);
        drop_ml();

        // K=0: straight to DONE, busy held while matrices_loaded stays high.
        start_run(0, 8, 1);
        wait_fin(0);
        repeat (5) @(posedge clk);
        #1 chk("k0_busy", int'(busy), 1);
        drop_ml();

        // Async reset mid-run after two writes.
        start_run(2, 8, 1);
        for (int w = 0; w < 200 && n_wr < 2; w++) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("arst_outs", outs(), 0);
        ml = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("post_rst_wr", n_wr, 2);
        start_run(2, 8, 1);
        wait_fin(2);
        chk("s5_burst", last_v - first_v + 1, 12);
        drop_ml();

        // matrices_loaded held high: no restart; a one-cycle drop re-arms.
        start_run(2, 8, 1);
        wait_fin(2);
        repeat (10) @(posedge clk);
        #1;
        chk("s6_no_restart", n_vld, 12);
        chk("s6_one_fin", n_fin, 1);
        ml = 1'b0;
        start_run(2, 8, 1);
        wait_fin(2);
        chk("s6_burst", last_v - first_v + 1, 12);
        drop_ml();

        // Randomised K, FIFO size and pop pattern.
        for (int t = 0; t < 6; t++) begin
            int k, fs;
            k  = int'($urandom_range(4, 1));
            fs = int'($urandom_range(8, 1));
            start_run(k, fs, 2);
            wait_fin(k);
            drop_ml();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
